// File: rtl/pixel_filter_pkg.sv
// Shared types and helpers for the streaming pixel filter.
// Mode encoding and the luma approximation used by grey/threshold.
package pixel_filter_pkg;

    localparam int GW = 16;

    typedef enum logic [2:0] {
        FM_PASS   = 3'd0,
        FM_INVERT = 3'd1,
        FM_GREY   = 3'd2,
        FM_BLUR   = 3'd3,
        FM_GRAD   = 3'd4,
        FM_THRESH = 3'd5
    } filter_mode_e;

    // (R + 2G + B) >> 2 with two guard bits so the sum never wraps
    function automatic logic [GW+1:0] grey_of(
        input logic [GW-1:0] r,
        input logic [GW-1:0] g,
        input logic [GW-1:0] b
    );
        logic [GW+1:0] s;
        s = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        return s >> 2;
    endfunction

endpackage

// File: rtl/pixel_filter_pipe_n_if.sv
// Pixel stream bundle between the read FIFOs and the LCD controller.
// master drives pixels/config, slave is the filter.
interface pixel_filter_pipe_n_if #(
    parameter int DW = 8,
    parameter int CH = 3,
    parameter int CW = 10
);
    logic              iFrame_Start;
    logic [2:0]        iMode;
    logic [DW-1:0]     iThreshold;
    logic              iValid;
    logic [CH*DW-1:0]  iData;
    logic              oValid;
    logic [CH*DW-1:0]  oData;
    logic [CW-1:0]     oCol;
    logic              oLine_Done;

    modport master (
        output iFrame_Start, iMode, iThreshold,
        output iValid, iData,
        input  oValid, oData, oCol, oLine_Done
    );

    modport slave (
        input  iFrame_Start, iMode, iThreshold,
        input  iValid, iData,
        output oValid, oData, oCol, oLine_Done
    );
endinterface

// File: rtl/box_window_acc.sv
// Per-channel WIN-deep pixel history with running sum.
// Column 0 replicates the first pixel across the whole window.
module box_window_acc #(
    parameter int DW  = 8,
    parameter int WIN = 4
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          load_edge,
    input  logic          shift_en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] avg,
    output logic [DW-1:0] prev
);
    localparam int LG = $clog2(WIN);
    localparam int SW = DW + LG;

    logic [DW-1:0] r_win [WIN];
    logic [SW-1:0] r_sum;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            for (int i = 0; i < WIN; i++)
                r_win[i] <= '0;
            r_sum <= '0;
        end else if (shift_en) begin
            if (load_edge) begin
                for (int i = 0; i < WIN; i++)
                    r_win[i] <= din;
                r_sum <= SW'(din) << LG;
            end else begin
                r_win[0] <= din;
                for (int i = 1; i < WIN; i++)
                    r_win[i] <= r_win[i-1];
                r_sum <= r_sum + SW'(din)
                       - SW'(r_win[WIN-1]);
            end
        end
    end

    assign avg  = DW'(r_sum >> LG);
    // slot 1 equals slot 0 at column 0, so gradient reads 0 there
    assign prev = r_win[1];

endmodule

// File: rtl/pixel_filter_pipe_n.sv
// Two-stage streaming pixel filter with per-frame mode/threshold latch.
// Stage 1 tracks column and window; stage 2 applies the mode.
module pixel_filter_pipe_n
    import pixel_filter_pkg::*;
#(
    parameter int DW     = 8,
    parameter int CH     = 3,
    parameter int WIN    = 4,
    parameter int LINE_W = 640,
    parameter int CW     = $clog2(LINE_W)
) (
    input logic                  Clock,
    input logic                  Resetn,
    pixel_filter_pipe_n_if.slave bus
);
    localparam int PW = CH * DW;

    logic [2:0]    r_mode;
    logic [DW-1:0] r_thr;
    logic [CW-1:0] r_col;

    logic          r_s1_v;
    logic [PW-1:0] r_s1_pix;
    logic [CW-1:0] r_s1_col;
    logic          r_s1_done;

    logic          r_o_v;
    logic [PW-1:0] r_o_data;
    logic [CW-1:0] r_o_col;
    logic          r_o_done;

    logic [CW-1:0] w_col_cur;
    logic          w_last;
    logic          w_edge;
    logic          w_s2_en;
    logic [PW-1:0] w_avg;
    logic [PW-1:0] w_prev;
    logic [PW-1:0] w_diff;
    logic [DW-1:0] w_grey;
    logic [PW-1:0] w_res;

    assign w_col_cur = bus.iFrame_Start ? '0 : r_col;
    assign w_last    = (w_col_cur == CW'(LINE_W - 1));
    assign w_edge    = (w_col_cur == '0);
    assign w_s2_en   = r_s1_v & ~bus.iFrame_Start;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [DW-1:0] w_cur;
        logic [DW-1:0] w_prv;

        box_window_acc #(.DW(DW), .WIN(WIN)) u_win (
            .Clock     (Clock),
            .Resetn    (Resetn),
            .load_edge (w_edge),
            .shift_en  (bus.iValid),
            .din       (bus.iData[c*DW +: DW]),
            .avg       (w_avg[c*DW +: DW]),
            .prev      (w_prev[c*DW +: DW])
        );

        assign w_cur = r_s1_pix[c*DW +: DW];
        assign w_prv = w_prev[c*DW +: DW];
        assign w_diff[c*DW +: DW] = (w_cur >= w_prv)
                                  ? w_cur - w_prv
                                  : w_prv - w_cur;
    end

    if (CH == 3) begin : g_grey3
        assign w_grey = DW'(grey_of(
            GW'(r_s1_pix[0*DW +: DW]),
            GW'(r_s1_pix[1*DW +: DW]),
            GW'(r_s1_pix[2*DW +: DW])));
    end else begin : g_grey1
        assign w_grey = r_s1_pix[0 +: DW];
    end

    always_comb begin
        w_res = r_s1_pix;
        unique case (1'b1)
            r_mode == FM_INVERT: w_res = ~r_s1_pix;
            r_mode == FM_GREY:
                if (CH == 3) w_res = {CH{w_grey}};
            r_mode == FM_BLUR:   w_res = w_avg;
            r_mode == FM_GRAD:   w_res = w_diff;
            r_mode == FM_THRESH:
                w_res = (w_grey >= r_thr) ? '1 : '0;
            default:             w_res = r_s1_pix;
        endcase
    end

    // config latch, column tracking and stage 1
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_mode    <= '0;
            r_thr     <= '0;
            r_col     <= '0;
            r_s1_v    <= 1'b0;
            r_s1_pix  <= '0;
            r_s1_col  <= '0;
            r_s1_done <= 1'b0;
        end else begin
            if (bus.iFrame_Start) begin
                r_mode <= bus.iMode;
                r_thr  <= bus.iThreshold;
            end
            r_s1_v <= bus.iValid;
            if (bus.iValid) begin
                r_s1_pix  <= bus.iData;
                r_s1_col  <= w_col_cur;
                r_s1_done <= w_last;
                r_col     <= w_last ? '0
                           : w_col_cur + CW'(1);
            end else if (bus.iFrame_Start) begin
                r_col <= '0;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_o_v    <= 1'b0;
            r_o_data <= '0;
            r_o_col  <= '0;
            r_o_done <= 1'b0;
        end else begin
            r_o_v    <= w_s2_en;
            r_o_done <= w_s2_en & r_s1_done;
            if (w_s2_en) begin
                r_o_data <= w_res;
                r_o_col  <= r_s1_col;
            end
        end
    end

    assign bus.oValid     = r_o_v;
    assign bus.oData      = r_o_data;
    assign bus.oCol       = r_o_col;
    assign bus.oLine_Done = r_o_done;

endmodule

// File: tb/tb_pixel_filter_pipe_n.sv
// Directed and random stimulus against a line-history reference model.
// Small line width so wrap and line-done occur often.
module tb_pixel_filter_pipe_n;
    localparam int DW = 8;
    localparam int CH = 3;
    localparam int WIN = 4;
    localparam int LW = 8;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rstn = 1'b0;

    pixel_filter_pipe_n_if #(.DW(DW), .CH(CH), .CW(CW)) bus ();

    pixel_filter_pipe_n #(
        .DW(DW), .CH(CH), .WIN(WIN), .LINE_W(LW)
    ) dut (
        .Clock  (clk),
        .Resetn (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    int m_mode, m_thr, m_col;
    logic [23:0] hist [LW];
    bit          m1_v, m2_v;
    logic [23:0] m1_d, m2_d;
    int          m1_c, m2_c;
    bit          m1_l, m2_l;

    function automatic int lum(input logic [23:0] p);
        return (int'(p[7:0]) + 2 * int'(p[15:8])
              + int'(p[23:16])) / 4;
    endfunction

    function automatic logic [23:0] ref_px(input int col);
        logic [23:0] p;
        logic [23:0] r;
        logic [23:0] q;
        int s, a, b, idx, g;
        p = hist[col];
        r = p;
        case (m_mode)
            1: r = ~p;
            2: begin
                g = lum(p);
                r = {8'(g), 8'(g), 8'(g)};
            end
            3: for (int c = 0; c < CH; c++) begin
                s = 0;
                for (int k = 0; k < WIN; k++) begin
                    idx = (col - k < 0) ? 0 : col - k;
                    q = hist[idx];
                    s += int'(q[c*8 +: 8]);
                end
                r[c*8 +: 8] = 8'(s / WIN);
            end
            4: for (int c = 0; c < CH; c++) begin
                q = hist[(col == 0) ? 0 : col - 1];
                a = int'(p[c*8 +: 8]);
                b = int'(q[c*8 +: 8]);
                r[c*8 +: 8] = 8'((a > b) ? a - b : b - a);
            end
            5: r = (lum(p) >= m_thr) ? 24'hFFFFFF : 24'h0;
            default: r = p;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_thr = 0;
        m_col = 0;
        m1_v = 0;
        m2_v = 0;
    endtask

    task automatic step(input bit fs, input int mode,
                        input int thr, input bit v,
                        input logic [23:0] d);
        int col;
        bus.iFrame_Start = fs;
        bus.iMode = 3'(mode);
        bus.iThreshold = 8'(thr);
        bus.iValid = v;
        bus.iData = d;
        if (fs) begin
            m_mode = mode;
            m_thr = thr;
            m_col = 0;
        end
        m2_v = fs ? 1'b0 : m1_v;
        m2_d = m1_d;
        m2_c = m1_c;
        m2_l = m1_l;
        m1_v = v;
        if (v) begin
            col = m_col;
            hist[col] = d;
            m1_d = ref_px(col);
            m1_c = col;
            m1_l = (col == LW - 1);
            m_col = (col == LW - 1) ? 0 : col + 1;
        end
        @(posedge clk);
        #1;
        nvec++;
        assert (bus.oValid === m2_v) else begin
            nerr++;
            $error("FAIL oValid: got %0b want %0b",
                   bus.oValid, m2_v);
        end
        if (m2_v) begin
            nvec++;
            assert (bus.oData === m2_d) else begin
                nerr++;
                $error("FAIL oData col%0d: got %06h want %06h",
                       m2_c, bus.oData, m2_d);
            end
            nvec++;
            assert (bus.oCol === CW'(m2_c)) else begin
                nerr++;
                $error("FAIL oCol: got %0d want %0d",
                       bus.oCol, m2_c);
            end
        end
        nvec++;
        assert (bus.oLine_Done === (m2_v & m2_l)) else begin
            nerr++;
            $error("FAIL oLine_Done: got %0b want %0b",
                   bus.oLine_Done, m2_v & m2_l);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.iFrame_Start = 1'b0;
        bus.iValid = 1'b0;
        bus.iData = 24'h0;
        bus.iMode = 3'd0;
        bus.iThreshold = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        nvec++;
        assert ({bus.oValid, bus.oData, bus.oCol,
                 bus.oLine_Done} === 29'd0) else begin
            nerr++;
            $error("FAIL reset: got v%0b d%06h c%0d l%0b want 0",
                   bus.oValid, bus.oData, bus.oCol,
                   bus.oLine_Done);
        end
        rstn = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 7, 0, 0, 24'h0);
    endtask

    initial begin
        do_reset();

        // mode 0 after reset
        step(0, 0, 0, 1, 24'h102030);
        step(0, 0, 0, 1, 24'h405060);
        idle(2);

        // box blur
        step(1, 3, 0, 1, 24'd8);
        step(0, 0, 0, 1, 24'd16);
        step(0, 0, 0, 1, 24'd24);
        step(0, 0, 0, 1, 24'd32);
        step(0, 0, 0, 1, 24'd40);
        idle(2);

        // gradient
        step(1, 4, 0, 1, 24'd100);
        step(0, 0, 0, 1, 24'd90);
        step(0, 0, 0, 1, 24'd130);
        idle(2);

        // threshold
        step(1, 5, 8'h80, 1, 24'h808080);
        step(0, 0, 0, 1, 24'h7F7F7F);
        idle(2);

        // grey then line wrap with 10 pixels
        step(1, 2, 0, 1, 24'h204080);
        idle(2);
        step(1, 0, 0, 1, 24'($urandom));
        for (int i = 0; i < 9; i++)
            step(0, 0, 0, 1, 24'($urandom));
        idle(2);

        // mode change without frame start is ignored
        step(0, 1, 0, 1, 24'h112233);
        idle(2);
        step(0, 1, 0, 1, 24'hAAAAAA);
        step(0, 1, 0, 1, 24'h555555);
        step(1, 1, 0, 1, 24'h00FF00);
        idle(3);

        // reset mid-line
        step(1, 3, 0, 1, 24'h010203);
        step(0, 3, 0, 1, 24'h040506);
        step(0, 3, 0, 1, 24'h070809);
        do_reset();
        step(0, 3, 0, 1, 24'hC0FFEE);
        idle(2);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 29) == 0),
                 int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) != 0),
                 24'($urandom));
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
